// File: rtl/mips_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_if_pkg
// Description : Shared definitions for the instruction fetch stage.
//               - RESET_PC / EXC_VECTOR defaults
//               - fetch state encoding {IF_RUN, IF_FAULT}
//               - ROM word-window bases and mask (text @0x0000, exc @0x8000,
//                 256 words each)
//               - buffer entry type {pc, instr}
//               - pc_is_legal(): fetch address legality check
// Revision    : 1.0 - initial release
// ============================================================================
package mips_if_pkg;

    localparam logic [31:0] C_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] C_EXC_VECTOR   = 32'h0002_0000;

    localparam logic [15:0] C_TEXT_BASE    = 16'h0000;
    localparam logic [15:0] C_EXC_BASE     = 16'h8000;
    localparam int          C_WINDOW_WORDS = 256;
    // Selects the word-index bits above the window offset.
    localparam logic [15:0] C_WINDOW_MASK  = ~16'(C_WINDOW_WORDS - 1);

    typedef enum logic [0:0] {
        IF_RUN   = 1'b0,
        IF_FAULT = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // A pc is fetchable when word aligned, inside the 18-bit ROM byte space,
    // and its word index lands in either the text or the exception window.
    function automatic logic pc_is_legal(input logic [31:0] pc);
        logic [15:0] word_idx;
        logic [15:0] win;
        word_idx = pc[17:2];
        win      = word_idx & C_WINDOW_MASK;
        return (pc[1:0] == 2'b00) && (pc[31:18] == 14'd0) &&
               ((win == C_TEXT_BASE) || (win == C_EXC_BASE));
    endfunction

endpackage : mips_if_pkg
`default_nettype wire

// File: rtl/if_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo2
// Description : Two-entry FIFO of if_entry_t feeding the decode handshake.
//               The head is held in its own register so that it keeps the
//               last delivered entry when the FIFO drains or is flushed.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_push/i_data   - write entry at tail
//               i_pop           - remove head (ignored when empty)
//               i_flush         - drop all entries (wins over push/pop)
//               o_count         - occupancy 0..2
//               o_head          - current head entry
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo2
    import mips_if_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  if_entry_t  i_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [1:0] o_count,
    output if_entry_t  o_head
);

    localparam logic [1:0] C_FULL = 2'd2;

    logic [1:0] r_count;
    if_entry_t  r_head;
    if_entry_t  r_tail;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves at the
    // same edge.
    assign w_push = i_push && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == C_FULL) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == C_FULL) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule : if_fifo2
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage in front of the instruction ROM. Owns the PC,
//               drives ROM address/chip select, buffers {pc, instr} in a
//               2-entry FIFO and hands them to decode over valid/ready.
//               Handles exception (highest priority) and branch redirects,
//               and enters a sticky FAULT state on an illegal fetch pc.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               rom_addr, rom_cs, rom_data  - ROM interface
//               redirect_valid/redirect_pc  - branch/jump redirect
//               exc_valid                   - exception redirect, clears fault
//               if_valid/if_ready           - decode handshake
//               if_instr, if_pc             - buffer head
//               if_fault                    - sticky fetch fault
//               perf_fetch_cnt/perf_stall_cnt (only with IF_PERF_CNT_EN)
// Options     : IF_PERF_CNT_EN - adds fetch / full-stall event counters
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import mips_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = C_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = C_EXC_VECTOR,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        if_fault
);

    localparam logic [1:0] C_DEPTH = 2'(BUF_DEPTH);

    if_state_e  r_state;
    if_state_e  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    logic        w_pc_legal;
    logic        w_pop;
    logic        w_fetch;
    logic        w_flush;
    logic [1:0]  w_count;
    logic [1:0]  w_occ_after_pop;
    if_entry_t   w_head;
    if_entry_t   w_push_data;

    assign w_pc_legal      = pc_is_legal(r_pc);
    assign w_pop           = if_valid && if_ready;
    // Pop only happens with count >= 1, so this cannot underflow.
    assign w_occ_after_pop = w_count - {1'b0, w_pop};

    // ------------------------------------------------------------------
    // State and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IF_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, next pc, fetch and flush decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fetch      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IF_RUN: begin
                if (exc_valid) begin
                    w_pc_next = EXC_VECTOR;
                    w_flush   = 1'b1;
                end else if (redirect_valid) begin
                    // An illegal target is caught on the following cycle.
                    w_pc_next = redirect_pc;
                    w_flush   = 1'b1;
                end else if (!w_pc_legal) begin
                    w_state_next = IF_FAULT;
                end else if (w_occ_after_pop < C_DEPTH) begin
                    w_fetch   = 1'b1;
                    w_pc_next = r_pc + 32'd4;
                end
            end
            IF_FAULT: begin
                // Branch redirects are ignored here; only an exception
                // can restart fetching.
                if (exc_valid) begin
                    w_state_next = IF_RUN;
                    w_pc_next    = EXC_VECTOR;
                    w_flush      = 1'b1;
                end
            end
            default: begin
                w_state_next = IF_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = rom_data;

    if_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Chip select is qualified with rst_n so the ROM is idle while the
    // stage is held in reset.
    assign rom_cs   = w_fetch && rst_n;
    assign rom_addr = r_pc[17:2];
    assign if_valid = (w_count != 2'd0);
    assign if_pc    = w_head.pc;
    assign if_instr = w_head.instr;
    assign if_fault = (r_state == IF_FAULT);

`ifdef IF_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic        w_stall;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Fetch was possible in every respect except buffer space.
    assign w_stall = (r_state == IF_RUN) && w_pc_legal && !exc_valid &&
                     !redirect_valid && (w_count == C_DEPTH) && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule : instr_fetch
`default_nettype wire
